// File: rtl/sysex_word_packer.sv
// sysex_word_packer
// Packs a MIDI SysEx byte stream into BPW-byte words tagged with a byte
// count and first/last-of-message flags, and queues them in a show-ahead
// FIFO drained from the register-bus side. Partial words are committed on
// end of message, on an explicit flush pulse, or after an idle timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no partial word held; next accepted byte opens a new word
// S_FILL   | partial word held; accepting bytes into lanes 1..BPW-1
// S_COMMIT | one-cycle FIFO write of the assembled word; no byte accepted
module sysex_word_packer #(
  parameter int BPW       = 3,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int TIMEOUT   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_rd,
  output logic                       in_busy,
  input  logic                       flush,
  input  logic                       out_rd,
  output logic                       out_rvalid,
  output logic [8*BPW-1:0]           out_rdata,
  output logic [$clog2(BPW+1)-1:0]   out_rlen,
  output logic                       out_rfirst,
  output logic                       out_rlast,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int LW  = $clog2(BPW + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = AW + 1;
  localparam int IW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DW  = 8 * BPW;
  localparam int WW  = LW + 2 + DW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   cnt;
  logic [DW-1:0]   lanes;
  logic            last_flag;
  logic            first_pend;
  logic [IW-1:0]   idle_cnt;
  logic            timeout_hit;
  logic            commit;

  logic [WW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LVW-1:0]  level_q, level_nxt;
  logic            busy_q;
  logic            pop;
  logic [WW-1:0]   head;

  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IW'(TIMEOUT));
  assign in_rd       = in_valid & ~busy_q & ((state == S_IDLE) | (state == S_FILL));

  // Next-state decode: word completion, flush and timeout all funnel into S_COMMIT.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_rd) state_nxt = (in_last || BPW == 1) ? S_COMMIT : S_FILL;
      end
      S_FILL: begin
        if (in_rd) begin
          if (in_last || cnt == LW'(BPW - 1) || flush) state_nxt = S_COMMIT;
        end else if (flush || timeout_hit) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Lane assembly, byte count and message flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes      <= '0;
      cnt        <= '0;
      last_flag  <= 1'b0;
      first_pend <= 1'b1;
    end else begin
      if (in_rd && state == S_IDLE) begin
        lanes             <= '0;
        lanes[DW-1 -: 8]  <= in_data;
        cnt               <= LW'(1);
        last_flag         <= in_last;
      end else if (in_rd && state == S_FILL) begin
        for (int i = 1; i < BPW; i++) begin
          if (cnt == LW'(i)) lanes[8*(BPW-1-i) +: 8] <= in_data;
        end
        cnt       <= cnt + LW'(1);
        last_flag <= in_last;
      end
      if (commit) first_pend <= last_flag;
    end
  end

  // Idle counter: only runs while a partial word waits in S_FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != S_FILL || in_rd) begin
      idle_cnt <= '0;
    end else if (TIMEOUT != 0 && idle_cnt != '1) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign pop       = out_rd & (level_q != '0);
  assign level_nxt = level_q + LVW'(commit) - LVW'(pop);

  // FIFO pointers, occupancy and the registered almost-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_nxt;
      busy_q  <= (level_nxt >= LVW'(DEPTH - AF_MARGIN));
    end
  end

  // FIFO storage; contents need no reset since outputs are gated by out_rvalid.
  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr] <= {cnt, first_pend, last_flag, lanes};
  end

  // The almost-full margin must always leave room for the pending commit.
  always @(posedge clk) begin
    if (rst_n && commit) assert (level_q < LVW'(DEPTH));
  end

  assign head       = (level_q != '0) ? mem[rd_ptr] : '0;
  assign out_rvalid = (level_q != '0);
  assign out_rdata  = head[DW-1:0];
  assign out_rlast  = head[DW];
  assign out_rfirst = head[DW+1];
  assign out_rlen   = head[WW-1 -: LW];
  assign level      = level_q;
  assign in_busy    = busy_q;

endmodule

// File: tb/tb_sysex_word_packer.sv
// tb_sysex_word_packer
// Drives directed and random byte streams into the packer and compares every
// cycle against a message-level reference model built from byte queues.
module tb_sysex_word_packer;

  localparam int BPW       = 3;
  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;
  localparam int TIMEOUT   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_rd;
  logic        in_busy;
  logic        flush = 1'b0;
  logic        out_rd = 1'b0;
  logic        out_rvalid;
  logic [23:0] out_rdata;
  logic [1:0]  out_rlen;
  logic        out_rfirst;
  logic        out_rlast;
  logic [2:0]  level;

  sysex_word_packer #(.BPW(BPW), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_rd(in_rd), .in_busy(in_busy), .flush(flush), .out_rd(out_rd),
    .out_rvalid(out_rvalid), .out_rdata(out_rdata), .out_rlen(out_rlen),
    .out_rfirst(out_rfirst), .out_rlast(out_rlast), .level(level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0]  m_bytes[$];
  logic [63:0] m_fifo[$];
  bit          m_commit, m_lastf, m_first, m_busy;
  int          m_idle;
  logic [63:0] dut_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_word(input int len, input bit first, input bit last,
                                          input logic [23:0] data);
    logic [63:0] w;
    w = '0;
    w[23:0]  = data;
    w[24]    = last;
    w[25]    = first;
    w[27:26] = len[1:0];
    return w;
  endfunction

  function automatic logic [63:0] obs_word();
    return {36'b0, out_rlen, out_rfirst, out_rlast, out_rdata};
  endfunction

  task automatic model_reset();
    m_bytes.delete();
    m_fifo.delete();
    m_commit = 0; m_lastf = 0; m_first = 1; m_busy = 0; m_idle = 0;
  endtask

  task automatic model_commit_word();
    logic [23:0] d;
    d = '0;
    for (int i = 0; i < m_bytes.size(); i++) d[8*(BPW-1-i) +: 8] = m_bytes[i];
    m_fifo.push_back(mk_word(m_bytes.size(), m_first, m_lastf, d));
    m_first = m_lastf;
    m_bytes.delete();
    m_commit = 0;
    m_idle = 0;
  endtask

  task automatic model_update(input logic [7:0] d, input bit l, input bit f, input bit r, input bit rd);
    bit was_fill;
    if (r && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (m_commit) begin
      model_commit_word();
    end else if (rd) begin
      was_fill = (m_bytes.size() > 0);
      m_bytes.push_back(d);
      m_idle = 0;
      if (l || m_bytes.size() == BPW) begin m_commit = 1; m_lastf = l; end
      else if (f && was_fill)         begin m_commit = 1; m_lastf = 0; end
    end else if (m_bytes.size() > 0) begin
      if (f || (TIMEOUT != 0 && m_idle == TIMEOUT)) begin m_commit = 1; m_lastf = 0; end
      else m_idle++;
    end
    m_busy = (m_fifo.size() >= DEPTH - AF_MARGIN);
  endtask

  task automatic check_outputs();
    chk("out_rvalid", 64'(out_rvalid), 64'(m_fifo.size() > 0));
    chk("level", 64'(level), 64'(m_fifo.size()));
    chk("in_busy", 64'(in_busy), 64'(m_busy));
    if (m_fifo.size() > 0) chk("head", obs_word(), m_fifo[0]);
    else                   chk("head_empty", obs_word(), 64'd0);
    if (level > 3'(DEPTH)) chk("level_bound", 64'(level), 64'(DEPTH));
  endtask

  // One clock: apply inputs after the falling edge, check in_rd, advance model, check outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit f, input bit r,
                      output bit took);
    bit exp_rd;
    in_valid = v; in_data = d; in_last = l; flush = f; out_rd = r;
    #1;
    exp_rd = v && !m_busy && !m_commit;
    chk("in_rd", 64'(in_rd), 64'(exp_rd));
    took = exp_rd;
    if (r && out_rvalid) dut_log.push_back(obs_word());
    @(posedge clk);
    model_update(d, l, f, r, exp_rd);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_step();
    bit t;
    step(0, 8'h00, 0, 0, 0, t);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l);
    bit t;
    t = 0;
    for (int k = 0; k < 50 && !t; k++) step(1, d, l, 0, 0, t);
    if (!t) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit t;
    int k;
    k = 0;
    while ((m_fifo.size() > 0 || m_commit || out_rvalid) && k < 60) begin
      step(0, 8'h00, 0, 0, 1, t);
      k++;
    end
    if (k >= 60) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    in_valid = 0; in_last = 0; flush = 0; out_rd = 0; in_data = '0;
    #1;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_rvalid", 64'(out_rvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_busy", 64'(in_busy), 64'd0);
    chk("rst_head", obs_word(), 64'd0);
    chk("rst_in_rd", 64'(in_rd), 64'd0);
    @(negedge clk);
    rst_n = 1;
    dut_log.delete();
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [63:0] exp);
    if (dut_log.size() > idx) chk(tag, dut_log[idx], exp);
    else chk({tag, "_missing"}, 64'(dut_log.size()), 64'(idx + 1));
  endtask

  initial begin
    logic [7:0] seq1 [6];
    bit t;
    int idx;

    model_reset();
    @(negedge clk);
    do_reset();

    // canonical SysEx message, two full words
    seq1 = '{8'hF0, 8'h7E, 8'h7F, 8'h09, 8'h01, 8'hF7};
    for (int i = 0; i < 6; i++) send_byte(seq1[i], i == 5);
    drain();
    chk("t1_count", 64'(dut_log.size()), 64'd2);
    chk_log("t1_w0", 0, mk_word(3, 1, 0, 24'hF07E7F));
    chk_log("t1_w1", 1, mk_word(3, 0, 1, 24'h0901F7));

    // partial final word
    dut_log.delete();
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
    drain();
    chk("t2_count", 64'(dut_log.size()), 64'd2);
    chk_log("t2_w0", 0, mk_word(3, 1, 0, 24'h112233));
    chk_log("t2_w1", 1, mk_word(1, 0, 1, 24'h440000));

    // idle timeout: decision after TIMEOUT+1 idle cycles, write in the following one
    dut_log.delete();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    for (int k = 1; k <= TIMEOUT + 1; k++) idle_step();
    chk("to_early", 64'(out_rvalid), 64'd0);
    idle_step();
    chk("to_commit", 64'(out_rvalid), 64'd1);
    drain();
    chk_log("t3_w0", 0, mk_word(2, 1, 0, 24'hAABB00));

    // forced flush of a one-byte word
    do_reset();
    send_byte(8'hCC, 0);
    step(0, 8'h00, 0, 1, 0, t);
    idle_step();
    send_byte(8'hDD, 1);
    drain();
    chk("t4_count", 64'(dut_log.size()), 64'd2);
    chk_log("t4_w0", 0, mk_word(1, 1, 0, 24'hCC0000));
    chk_log("t4_w1", 1, mk_word(1, 0, 1, 24'hDD0000));

    // back-pressure: FIFO fills to DEPTH-AF_MARGIN and acceptance stops
    dut_log.delete();
    idx = 0;
    for (int k = 0; k < 30; k++) begin
      step(1, 8'h30 + 8'(idx), idx == 11, 0, 0, t);
      if (t) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd9);
    chk("bp_level", 64'(level), 64'd3);
    chk("bp_busy", 64'(in_busy), 64'd1);
    step(1, 8'h30 + 8'(idx), idx == 11, 0, 1, t);
    if (t) idx++;
    for (int k = 0; k < 30 && idx < 12; k++) begin
      step(1, 8'h30 + 8'(idx), idx == 11, 0, 0, t);
      if (t) idx++;
    end
    chk("bp_resumed", 64'(idx), 64'd12);
    drain();
    chk("bp_count", 64'(dut_log.size()), 64'd4);
    chk_log("bp_w0", 0, mk_word(3, 1, 0, 24'h303132));
    chk_log("bp_w1", 1, mk_word(3, 0, 0, 24'h333435));
    chk_log("bp_w2", 2, mk_word(3, 0, 0, 24'h363738));
    chk_log("bp_w3", 3, mk_word(3, 0, 1, 24'h393A3B));

    // reset in the middle of a partial word
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 1);
    drain();
    chk("t6_count", 64'(dut_log.size()), 64'd1);
    chk_log("t6_w0", 0, mk_word(3, 1, 1, 24'h010203));

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(5, 0) == 0,
           $urandom_range(15, 0) == 0, $urandom_range(2, 0) == 0, t);
    end
    for (int k = 0; k < 20; k++) idle_step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
